// File: rtl/quantizer_block.sv
// Five-stage FP32 -> signed integer level quantizer: x * inv_scale, rounded to
// nearest-even and saturated to +/-(2^(LEVEL_BITS-1)-1). Any stall freezes the whole pipe.
module quantizer_block #(
  parameter int unsigned LEVEL_BITS  = 16,
  parameter logic [31:0] W_INV_SCALE = 32'h442AAAAB,
  parameter logic [31:0] A_INV_SCALE = 32'h48CCCCCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value_fp,
  input  logic        is_weight,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] level_int_reg,
  output logic        ovfl_reg,
  output logic        unfl_reg,
  output logic        excp_reg
);
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned INT_W  = 32;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned SH_W   = 6;
  localparam logic [INT_W:0] MAX_MAG = (33'd1 << (LEVEL_BITS - 1)) - 33'd1;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_e;

  logic advance;

  logic                    s1_v_q, s1_v_d, s1_sign_q, s1_sign_d, s1_w_q, s1_w_d;
  cls_e                    s1_cls_q, s1_cls_d;
  logic [7:0]              s1_exp_q, s1_exp_d;
  logic [MANT_W-1:0]       s1_mant_q, s1_mant_d;

  logic                    s2_v_q, s2_v_d, s2_sign_q, s2_sign_d;
  cls_e                    s2_cls_q, s2_cls_d;
  logic signed [EXP_W-1:0] s2_e_q, s2_e_d;
  logic [PROD_W-1:0]       s2_prod_q, s2_prod_d;
  logic [7:0]              s2_sexp;
  logic [MANT_W-1:0]       s2_smant;

  logic                    s3_v_q, s3_v_d, s3_sign_q, s3_sign_d;
  cls_e                    s3_cls_q, s3_cls_d;
  logic [INT_W-1:0]        s3_int_q, s3_int_d;
  logic                    s3_guard_q, s3_guard_d, s3_sticky_q, s3_sticky_d, s3_povf_q, s3_povf_d;
  logic signed [EXP_W-1:0] s3_r;
  logic [SH_W-1:0]         s3_sh;
  logic [PROD_W-1:0]       s3_full;

  logic                    s4_v_q, s4_v_d, s4_sign_q, s4_sign_d, s4_povf_q, s4_povf_d;
  cls_e                    s4_cls_q, s4_cls_d;
  logic [INT_W:0]          s4_mag_q, s4_mag_d;

  logic                    out_valid_q, out_valid_d;
  logic [INT_W-1:0]        level_q, level_d, sat_mag;
  logic                    ovfl_q, ovfl_d, unfl_q, unfl_d, excp_q, excp_d;

  assign advance       = !(out_valid_q && !out_ready);
  assign in_ready      = advance;
  assign out_valid     = out_valid_q;
  assign level_int_reg = level_q;
  assign ovfl_reg      = ovfl_q;
  assign unfl_reg      = unfl_q;
  assign excp_reg      = excp_q;

  // S1: unpack and classify; denormals flush to zero
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_sign_d = s1_sign_q;
    s1_w_d    = s1_w_q;
    s1_cls_d  = s1_cls_q;
    s1_exp_d  = s1_exp_q;
    s1_mant_d = s1_mant_q;
    if (advance) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_sign_d = value_fp[31];
        s1_w_d    = is_weight;
        s1_exp_d  = value_fp[30:23];
        s1_mant_d = {1'b1, value_fp[22:0]};
        if (value_fp[30:23] == 8'h00)      s1_cls_d = CLS_ZERO;
        else if (value_fp[30:23] != 8'hFF) s1_cls_d = CLS_NORM;
        else if (value_fp[22:0] == '0)     s1_cls_d = CLS_INF;
        else                               s1_cls_d = CLS_NAN;
      end
    end
  end

  // S2: full-width mantissa product and unbiased combined exponent
  always_comb begin
    s2_sexp   = s1_w_q ? W_INV_SCALE[30:23] : A_INV_SCALE[30:23];
    s2_smant  = {1'b1, s1_w_q ? W_INV_SCALE[22:0] : A_INV_SCALE[22:0]};
    s2_v_d    = s2_v_q;
    s2_sign_d = s2_sign_q;
    s2_cls_d  = s2_cls_q;
    s2_e_d    = s2_e_q;
    s2_prod_d = s2_prod_q;
    if (advance) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_sign_d = s1_sign_q;
        s2_cls_d  = s1_cls_q;
        s2_e_d    = $signed({2'b00, s1_exp_q}) + $signed({2'b00, s2_sexp}) - 10'sd254;
        s2_prod_d = PROD_W'(s1_mant_q) * PROD_W'(s2_smant);
      end
    end
  end

  // S3: product binary point sits at bit 46, so the right shift is 46 - e
  always_comb begin
    s3_r        = 10'sd46 - s2_e_q;
    s3_sh       = SH_W'(s3_r);
    s3_full     = '0;
    s3_v_d      = s3_v_q;
    s3_sign_d   = s3_sign_q;
    s3_cls_d    = s3_cls_q;
    s3_int_d    = s3_int_q;
    s3_guard_d  = s3_guard_q;
    s3_sticky_d = s3_sticky_q;
    s3_povf_d   = s3_povf_q;
    if (advance) begin
      s3_v_d = s2_v_q;
      if (s2_v_q) begin
        s3_sign_d   = s2_sign_q;
        s3_cls_d    = s2_cls_q;
        s3_int_d    = '0;
        s3_guard_d  = 1'b0;
        s3_sticky_d = 1'b0;
        s3_povf_d   = 1'b0;
        if (s3_r < 10'sd0) begin
          s3_povf_d = 1'b1;
        end else if (s3_r > 10'sd48) begin
          s3_sticky_d = |s2_prod_q;
        end else begin
          s3_full   = s2_prod_q >> s3_sh;
          s3_povf_d = |s3_full[PROD_W-1:INT_W];
          s3_int_d  = s3_full[INT_W-1:0];
          if (s3_sh != '0) begin
            s3_guard_d  = s2_prod_q[s3_sh - SH_W'(1)];
            s3_sticky_d = |(s2_prod_q & ((PROD_W'(1) << (s3_sh - SH_W'(1))) - PROD_W'(1)));
          end
        end
      end
    end
  end

  // S4: round half to even; the extra bit catches the carry out of 32 bits
  always_comb begin
    s4_v_d    = s4_v_q;
    s4_sign_d = s4_sign_q;
    s4_cls_d  = s4_cls_q;
    s4_mag_d  = s4_mag_q;
    s4_povf_d = s4_povf_q;
    if (advance) begin
      s4_v_d = s3_v_q;
      if (s3_v_q) begin
        s4_sign_d = s3_sign_q;
        s4_cls_d  = s3_cls_q;
        s4_povf_d = s3_povf_q;
        s4_mag_d  = {1'b0, s3_int_q} + (INT_W + 1)'(s3_guard_q & (s3_sticky_q | s3_int_q[0]));
      end
    end
  end

  // S5: saturate, apply sign and flags; data and flags change only with a new result
  always_comb begin
    sat_mag     = '0;
    out_valid_d = out_valid_q;
    level_d     = level_q;
    ovfl_d      = ovfl_q;
    unfl_d      = unfl_q;
    excp_d      = excp_q;
    if (advance) begin
      out_valid_d = s4_v_q;
      if (s4_v_q) begin
        ovfl_d = 1'b0;
        unfl_d = 1'b0;
        excp_d = 1'b0;
        case (s4_cls_q)
          CLS_NAN: excp_d = 1'b1;
          CLS_INF: begin
            excp_d  = 1'b1;
            sat_mag = MAX_MAG[INT_W-1:0];
          end
          CLS_NORM: begin
            if (s4_povf_q || (s4_mag_q > MAX_MAG)) begin
              ovfl_d  = 1'b1;
              sat_mag = MAX_MAG[INT_W-1:0];
            end else begin
              sat_mag = s4_mag_q[INT_W-1:0];
              unfl_d  = (s4_mag_q == '0);
            end
          end
          default: sat_mag = '0;
        endcase
        level_d = s4_sign_q ? (INT_W'(0) - sat_mag) : sat_mag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v_q <= 1'b0; s1_sign_q <= 1'b0; s1_w_q <= 1'b0; s1_cls_q <= CLS_ZERO;
      s1_exp_q <= '0; s1_mant_q <= '0;
      s2_v_q <= 1'b0; s2_sign_q <= 1'b0; s2_cls_q <= CLS_ZERO; s2_e_q <= '0; s2_prod_q <= '0;
      s3_v_q <= 1'b0; s3_sign_q <= 1'b0; s3_cls_q <= CLS_ZERO; s3_int_q <= '0;
      s3_guard_q <= 1'b0; s3_sticky_q <= 1'b0; s3_povf_q <= 1'b0;
      s4_v_q <= 1'b0; s4_sign_q <= 1'b0; s4_cls_q <= CLS_ZERO; s4_mag_q <= '0; s4_povf_q <= 1'b0;
      out_valid_q <= 1'b0; level_q <= '0; ovfl_q <= 1'b0; unfl_q <= 1'b0; excp_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d; s1_sign_q <= s1_sign_d; s1_w_q <= s1_w_d; s1_cls_q <= s1_cls_d;
      s1_exp_q <= s1_exp_d; s1_mant_q <= s1_mant_d;
      s2_v_q <= s2_v_d; s2_sign_q <= s2_sign_d; s2_cls_q <= s2_cls_d; s2_e_q <= s2_e_d;
      s2_prod_q <= s2_prod_d;
      s3_v_q <= s3_v_d; s3_sign_q <= s3_sign_d; s3_cls_q <= s3_cls_d; s3_int_q <= s3_int_d;
      s3_guard_q <= s3_guard_d; s3_sticky_q <= s3_sticky_d; s3_povf_q <= s3_povf_d;
      s4_v_q <= s4_v_d; s4_sign_q <= s4_sign_d; s4_cls_q <= s4_cls_d; s4_mag_q <= s4_mag_d;
      s4_povf_q <= s4_povf_d;
      out_valid_q <= out_valid_d; level_q <= level_d; ovfl_q <= ovfl_d; unfl_q <= unfl_d;
      excp_q <= excp_d;
    end
  end
endmodule

// File: tb/tb_quantizer_block.sv
// Bench for quantizer_block: directed vectors, latency/throughput, backpressure,
// mid-flight reset and random traffic against a real-arithmetic reference model.
module tb_quantizer_block;
  typedef struct packed {
    logic [31:0] lvl;
    logic        ovf;
    logic        unfl;
    logic        excp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] value_fp = '0;
  logic        is_weight = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] level_int_reg;
  logic        ovfl_reg, unfl_reg, excp_reg;

  always #5 clk = ~clk;

  quantizer_block dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .value_fp(value_fp),
    .is_weight(is_weight), .out_valid(out_valid), .out_ready(out_ready),
    .level_int_reg(level_int_reg), .ovfl_reg(ovfl_reg), .unfl_reg(unfl_reg), .excp_reg(excp_reg)
  );

  int    checks = 0;
  int    failures = 0;
  int    n_out = 0;
  res_t  exp_q[$];
  string cur_tag = "init";
  logic  s_in_ready, s_out_valid, s_acc;
  res_t  s_res;
  logic [15:0] hist = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic real fp_mag(input logic [31:0] v);
    return real'({1'b1, v[22:0]}) * (2.0 ** real'(int'(v[30:23]) - 150));
  endfunction

  // Reference: exact real product, nearest-even rounding, then saturation
  function automatic res_t model(input logic [31:0] v, input logic w);
    res_t        r;
    real         x, fl, fr;
    int unsigned mag;
    r = '0;
    if (v[30:23] == 8'hFF) begin
      r.excp = 1'b1;
      if (v[22:0] == '0) r.lvl = v[31] ? 32'hFFFF8001 : 32'h00007FFF;
      return r;
    end
    if (v[30:23] == 8'h00) return r;
    x = fp_mag(v) * fp_mag(w ? 32'h442AAAAB : 32'h48CCCCCD);
    if (x >= 32767.5) begin
      mag   = 32767;
      r.ovf = 1'b1;
    end else begin
      fl  = $floor(x);
      fr  = x - fl;
      mag = int'($rtoi(fl));
      if (fr > 0.5 || (fr == 0.5 && (mag % 2) == 1)) mag++;
      r.unfl = (mag == 0);
    end
    r.lvl = v[31] ? (32'd0 - mag) : mag;
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel == 0)      v[30:23] = 8'h00;
    else if (sel == 1) v[30:23] = 8'hFF;
    else if (sel == 2) begin
      v[22:0]  = '0;
      v[30:23] = 8'($urandom_range(100, 145));
    end else v[30:23] = 8'($urandom_range(95, 150));
    return v;
  endfunction

  // One clock: drive inputs, sample outputs, score transfers, advance to next negedge
  task automatic step(input logic iv, input logic [31:0] v, input logic w, input logic ordy,
                      input logic use_dir, input res_t dir);
    res_t e;
    in_valid = iv; value_fp = v; is_weight = w; out_ready = ordy;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_res       = {level_int_reg, ovfl_reg, unfl_reg, excp_reg};
    s_acc       = iv && in_ready && rst;
    hist        = {hist[14:0], out_valid};
    if (out_valid && ordy && rst) begin
      n_out++;
      if (exp_q.size() == 0) check({cur_tag, "_spurious"}, 64'(out_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        check(cur_tag, 64'(s_res), 64'(e));
      end
    end
    if (s_acc) exp_q.push_back(use_dir ? dir : model(v, w));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  logic [31:0] dv[9] = '{32'h40C00000, 32'hBABFFFE0, 32'h00000000, 32'h3C200013, 32'h42C80000,
                         32'hC2C80000, 32'h358637BD, 32'h7FC00000, 32'hFF800000};
  logic        dw[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  res_t        dr[9] = '{'{32'd4096, 1'b0, 1'b0, 1'b0}, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
                         '{32'd0, 1'b0, 1'b0, 1'b0}, '{32'd4096, 1'b0, 1'b0, 1'b0},
                         '{32'd32767, 1'b1, 1'b0, 1'b0}, '{32'hFFFF8001, 1'b1, 1'b0, 1'b0},
                         '{32'd0, 1'b0, 1'b1, 1'b0}, '{32'd0, 1'b0, 1'b0, 1'b1},
                         '{32'hFFFF8001, 1'b0, 1'b0, 1'b1}};

  initial begin
    logic [31:0] bv[8];
    res_t        held;
    int          idx, out0, budget;

    held = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level_int_reg), 64'd0);
    check("rst_flags", 64'({ovfl_reg, unfl_reg, excp_reg}), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    cur_tag = "directed";
    for (int i = 0; i < 9; i++) step(1'b1, dv[i], dw[i], 1'b1, 1'b1, dr[i]);
    idle(10);
    check("directed_count", 64'(n_out), 64'd9);

    cur_tag = "throughput";
    hist = '0;
    for (int i = 0; i < 8; i++) step(1'b1, rand_fp(), 1'($urandom), 1'b1, 1'b0, '0);
    idle(8);
    check("latency_and_burst", 64'(hist), 64'h07F8);

    cur_tag = "backpressure";
    for (int i = 0; i < 8; i++) bv[i] = rand_fp();
    idx  = 0;
    out0 = n_out;
    for (int c = 0; c < 20; c++) begin
      step(idx < 8, bv[idx % 8], 1'b1, !(c >= 5 && c <= 7), 1'b0, '0);
      if (s_acc) idx++;
      if (c == 5) begin
        check("bp_pipe_full", 64'(s_out_valid), 64'd1);
        held = s_res;
      end
      if (c >= 5 && c <= 7) check("bp_in_ready", 64'(s_in_ready), 64'd0);
      if (c >= 6 && c <= 8) check("bp_hold", 64'(s_res), 64'(held));
    end
    check("bp_count", 64'(n_out - out0), 64'd8);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    cur_tag = "midreset";
    for (int i = 0; i < 3; i++) step(1'b1, dv[i], dw[i], 1'b1, 1'b0, '0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_outputs", 64'({level_int_reg, ovfl_reg, unfl_reg, excp_reg}), 64'd0);
    hist = '0;
    idle(8);
    check("midrst_no_stale", 64'(hist[7:0]), 64'd0);
    hist = '0;
    step(1'b1, 32'h40C00000, 1'b1, 1'b1, 1'b0, '0);
    idle(9);
    check("midrst_latency", 64'(hist[9:0]), 64'h010);

    cur_tag = "random";
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_fp(), 1'($urandom), $urandom_range(0, 3) != 0,
           1'b0, '0);
    budget = 0;
    while (exp_q.size() != 0 && budget < 30) begin
      idle(1);
      budget++;
    end
    check("random_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
